// File: rtl/mu_error_scale.sv
// Forms error = desired - y_hat and scales it by mu_a into Q4.12, saturating, with a saturation counter.
// Latency 3 clocks, one sample per clock; no backpressure, never stalls. Optional MUE_ROUND_EN rounds the product.
// MUE_ROUND_EN defined: round half toward +inf before the shift; undefined: truncate toward -inf.
module mu_error_scale #(
    parameter int               WIDTH    = 16,
    parameter int               FRAC     = 12,
    parameter logic [WIDTH-1:0] MU_RESET = 16'h0080
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] desired,
    input  logic [WIDTH-1:0] y_hat,
    input  logic             adapt_en,
    input  logic             mu_load,
    input  logic [WIDTH-1:0] mu_in,
    input  logic             sat_clr,
    output logic             out_valid,
    output logic [WIDTH-1:0] mu_a_error,
    output logic [WIDTH-1:0] error_out,
    output logic             sat_flag,
    output logic [7:0]       sat_count
);

    localparam int PW = 2 * WIDTH;
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] mu_a;

    logic [WIDTH-1:0] err1, mu1;
    logic             sat1, v1, ae1;

    logic signed [PW-1:0] prod2;
    logic [WIDTH-1:0]     err2;
    logic                 sat2, v2, ae2;

    // Stage 1 combinational: widened subtract and clamp.
    logic [WIDTH:0]   diff;
    logic             diff_ovf;
    logic [WIDTH-1:0] diff_sat;

    always_comb begin
        diff     = {desired[WIDTH-1], desired} - {y_hat[WIDTH-1], y_hat};
        diff_ovf = diff[WIDTH] ^ diff[WIDTH-1];
        diff_sat = diff_ovf ? (diff[WIDTH] ? SAT_MIN : SAT_MAX) : diff[WIDTH-1:0];
    end

    // Stage 3 combinational: optional rounding, arithmetic shift, clamp.
    logic signed [PW-1:0] prod_adj, shifted;
    logic                 prod_ovf;
    logic [WIDTH-1:0]     prod_sat;

`ifdef MUE_ROUND_EN
    localparam logic signed [PW-1:0] HALF = PW'(1) << (FRAC - 1);
    always_comb prod_adj = prod2 + HALF;
`else
    always_comb prod_adj = prod2;
`endif

    always_comb begin
        shifted  = prod_adj >>> FRAC;
        // In range only when every bit above the result's sign bit matches it.
        prod_ovf = !((&shifted[PW-1:WIDTH-1]) || !(|shifted[PW-1:WIDTH-1]));
        prod_sat = prod_ovf ? (shifted[PW-1] ? SAT_MIN : SAT_MAX) : shifted[WIDTH-1:0];
    end

    logic prod_sat_ev, out_sat_ev;
    always_comb begin
        prod_sat_ev = ae2 && prod_ovf;
        out_sat_ev  = v2 && (sat2 || prod_sat_ev);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mu_a <= MU_RESET;
        end else if (mu_load) begin
            mu_a <= mu_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err1  <= '0;
            mu1   <= '0;
            sat1  <= 1'b0;
            v1    <= 1'b0;
            ae1   <= 1'b0;
            prod2 <= '0;
            err2  <= '0;
            sat2  <= 1'b0;
            v2    <= 1'b0;
            ae2   <= 1'b0;
        end else begin
            err1  <= diff_sat;
            mu1   <= mu_a;
            sat1  <= diff_ovf;
            v1    <= in_valid;
            ae1   <= adapt_en;
            prod2 <= $signed(err1) * $signed(mu1);
            err2  <= err1;
            sat2  <= sat1;
            v2    <= v1;
            ae2   <= ae1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            mu_a_error <= '0;
            error_out  <= '0;
            sat_flag   <= 1'b0;
        end else begin
            out_valid <= v2;
            if (v2) begin
                mu_a_error <= ae2 ? prod_sat : '0;
                error_out  <= err2;
                sat_flag   <= sat2 || prod_sat_ev;
            end else begin
                sat_flag   <= 1'b0;
            end
        end
    end

    // Clear takes priority, but a same-edge event still counts as the first one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_count <= '0;
        end else if (sat_clr) begin
            sat_count <= out_sat_ev ? 8'd1 : 8'd0;
        end else if (out_sat_ev && sat_count != 8'hFF) begin
            sat_count <= sat_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_mu_error_scale.sv
// Directed self-checking bench for mu_error_scale; expected values hand-computed.
module tb_mu_error_scale;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] desired, y_hat;
    logic        adapt_en;
    logic        mu_load;
    logic [15:0] mu_in;
    logic        sat_clr;
    logic        out_valid;
    logic [15:0] mu_a_error, error_out;
    logic        sat_flag;
    logic [7:0]  sat_count;

    int checks = 0;
    int errors = 0;

    mu_error_scale dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .desired    (desired),
        .y_hat      (y_hat),
        .adapt_en   (adapt_en),
        .mu_load    (mu_load),
        .mu_in      (mu_in),
        .sat_clr    (sat_clr),
        .out_valid  (out_valid),
        .mu_a_error (mu_a_error),
        .error_out  (error_out),
        .sat_flag   (sat_flag),
        .sat_count  (sat_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mu(input logic [15:0] m);
        mu_load = 1'b1;
        mu_in   = m;
        step();
        mu_load = 1'b0;
    endtask

    // One isolated sample, returns with its result on the outputs.
    task automatic send(input logic [15:0] d, input logic [15:0] y, input logic ae);
        desired  = d;
        y_hat    = y;
        adapt_en = ae;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        adapt_en = 1'b1;
        step();
        step();
    endtask

    logic [15:0] stream_exp [6];
    logic [15:0] round_exp;
    int          stale;

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        desired  = '0;
        y_hat    = '0;
        adapt_en = 1'b1;
        mu_load  = 1'b0;
        mu_in    = '0;
        sat_clr  = 1'b0;
        step();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mu_a_error", mu_a_error, 0);
        chk("rst_error_out", error_out, 0);
        chk("rst_sat_flag", sat_flag, 0);
        chk("rst_sat_count", sat_count, 0);
        reset = 1'b0;
        step();

        // Default mu 0x0080: 0x0800 * 0x0080 >> 12 = 0x0040.
        send(16'h1000, 16'h0800, 1'b1);
        chk("t1_out_valid", out_valid, 1);
        chk("t1_error_out", error_out, 16'h0800);
        chk("t1_mu_a_error", mu_a_error, 16'h0040);
        chk("t1_sat_flag", sat_flag, 0);
        step();
        chk("t1_bubble_valid", out_valid, 0);
        chk("t1_bubble_hold", mu_a_error, 16'h0040);

        load_mu(16'h1000);
        send(16'h7FFF, 16'h8000, 1'b1);
        chk("t2_error_out", error_out, 16'h7FFF);
        chk("t2_mu_a_error", mu_a_error, 16'h7FFF);
        chk("t2_sat_flag", sat_flag, 1);
        chk("t2_sat_count", sat_count, 1);

        load_mu(16'h7FFF);
        send(16'h2000, 16'h0000, 1'b1);
        chk("t3_mu_a_error", mu_a_error, 16'h7FFF);
        chk("t3_sat_flag", sat_flag, 1);
        chk("t3_sat_count", sat_count, 2);
        send(16'h2000, 16'h0000, 1'b0);
        chk("t3f_mu_a_error", mu_a_error, 16'h0000);
        chk("t3f_error_out", error_out, 16'h2000);
        chk("t3f_sat_flag", sat_flag, 0);
        chk("t3f_sat_count", sat_count, 2);

        load_mu(16'h0800);
        send(16'hFFFF, 16'h0000, 1'b1);
`ifdef MUE_ROUND_EN
        round_exp = 16'h0000;
`else
        round_exp = 16'hFFFF;
`endif
        chk("t4_mu_a_error", mu_a_error, round_exp);
        chk("t4_sat_flag", sat_flag, 0);

        // Back-to-back stream, load of 0x1000 on the edge sample 2 enters.
        stream_exp[0] = 16'h0080;
        stream_exp[1] = 16'h0100;
        stream_exp[2] = 16'h0180;
        stream_exp[3] = 16'h0400;
        stream_exp[4] = 16'h0500;
        stream_exp[5] = 16'h0600;
        for (int c = 0; c < 8; c++) begin
            in_valid = (c < 6);
            desired  = 16'((c + 1) * 16'h0100);
            y_hat    = '0;
            mu_load  = (c == 2);
            mu_in    = 16'h1000;
            step();
            if (c >= 2) begin
                chk($sformatf("t5_valid_%0d", c - 2), out_valid, 1);
                chk($sformatf("t5_mu_err_%0d", c - 2), mu_a_error, stream_exp[c-2]);
            end
        end
        in_valid = 1'b0;
        mu_load  = 1'b0;
        step();
        chk("t5_tail_valid", out_valid, 0);

        // 300 saturating samples push the counter into its ceiling.
        desired  = 16'h7FFF;
        y_hat    = 16'h8000;
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) step();
        in_valid = 1'b0;
        step();
        step();
        step();
        chk("t6_sat_count_sticky", sat_count, 8'd255);

        // Clear on the same edge as a saturating output.
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        chk("t6_clr_coincident_flag", sat_flag, 1);
        chk("t6_clr_coincident", sat_count, 1);
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        chk("t6_clr_alone", sat_count, 0);

        // Reset in the middle of a live stream.
        desired  = 16'h1000;
        y_hat    = 16'h0800;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("t7_pre_valid", out_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t7_rst_valid", out_valid, 0);
        chk("t7_rst_mu_a_error", mu_a_error, 0);
        chk("t7_rst_error_out", error_out, 0);
        in_valid = 1'b0;
        step();
        reset = 1'b0;
        stale = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (out_valid !== 1'b0) stale++;
        end
        chk("t7_no_stale_valid", stale, 0);

        // mu_a is back at its reset value.
        send(16'h1000, 16'h0800, 1'b1);
        chk("t8_mu_reset_valid", out_valid, 1);
        chk("t8_mu_reset_value", mu_a_error, 16'h0040);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
